// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath mux select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to the
// 3-bit ALUControl code consumed by the ALU.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute and writeback, with optional wait cycles for slow memory.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] StateDbg
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state, next_state, out_state;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic       pc_update, branch, ir_write, mem_write, reg_write, illegal_op;
  alu_op_t    alu_op;

  assign wait_done = (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= 4'd0;
      else if (state == S_FETCH || state == S_MEMREAD)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (wait_done) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: if (wait_done) next_state = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Reset acts on the outputs immediately so a write in flight is dropped
  // in the very cycle reset is raised.
  assign out_state = reset ? S_FETCH : state;

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (out_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = wait_done;
        pc_update = wait_done;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        illegal_op = !is_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB:   reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite  = !reset && (pc_update || (branch && Zero));
  assign IRWrite  = !reset && ir_write;
  assign MemWrite = !reset && mem_write;
  assign RegWrite = !reset && reg_write;
  assign Illegal  = !reset && illegal_op;
  assign ImmSrc   = imm_src_of(op);
  assign StateDbg = out_state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a phase-list model of each
// instruction predicts every output on every cycle, for MEM_WAIT 0 and 2.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EXR, P_EXI, P_AWB, P_BEQ, P_JAL} phase_t;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic       regw;
    logic [2:0] aluc;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      reset_v = 2'b11;
  logic [1:0]      f7_v    = 2'b00;
  logic [1:0]      zero_v  = 2'b00;
  logic [1:0][6:0] op_v    = '0;
  logic [1:0][2:0] f3_v    = '0;
  outs_t act0, act1, act_sel;

  multicycle_controller #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(reset_v[0]), .op(op_v[0]), .funct3(f3_v[0]),
    .funct7b5(f7_v[0]), .Zero(zero_v[0]),
    .PCWrite(act0.pcw), .AdrSrc(act0.adr), .MemWrite(act0.memw), .IRWrite(act0.irw),
    .ResultSrc(act0.res), .ALUSrcA(act0.srca), .ALUSrcB(act0.srcb), .ImmSrc(act0.imm),
    .RegWrite(act0.regw), .ALUControl(act0.aluc), .Illegal(act0.ill), .StateDbg(act0.st)
  );

  multicycle_controller #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(reset_v[1]), .op(op_v[1]), .funct3(f3_v[1]),
    .funct7b5(f7_v[1]), .Zero(zero_v[1]),
    .PCWrite(act1.pcw), .AdrSrc(act1.adr), .MemWrite(act1.memw), .IRWrite(act1.irw),
    .ResultSrc(act1.res), .ALUSrcA(act1.srca), .ALUSrcB(act1.srcb), .ImmSrc(act1.imm),
    .RegWrite(act1.regw), .ALUControl(act1.aluc), .Illegal(act1.ill), .StateDbg(act1.st)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  outs_t exp_o;
  logic  exp_valid = 1'b0;
  int    act_d = 0;
  string exp_tag = "";

  phase_t seq[$];
  bit     seq_last[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic legal(input logic [6:0] op);
    return op inside {LW, SW, RT, IT, BQ, JL};
  endfunction

  function automatic logic [1:0] imm_expect(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_expect(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] st_code(input phase_t p);
    case (p)
      P_F:     return S_FETCH;
      P_D:     return S_DECODE;
      P_MA:    return S_MEMADR;
      P_MR:    return S_MEMREAD;
      P_MWB:   return S_MEMWB;
      P_MW:    return S_MEMWRITE;
      P_EXR:   return S_EXECR;
      P_EXI:   return S_EXECI;
      P_AWB:   return S_ALUWB;
      P_BEQ:   return S_BEQ;
      default: return S_JAL;
    endcase
  endfunction

  // Instruction as a list of phases; wait phases repeat the memory step.
  function automatic void build_seq(input logic [6:0] op, input int mw);
    seq.delete();
    seq_last.delete();
    for (int i = 0; i <= mw; i++) begin seq.push_back(P_F); seq_last.push_back(i == mw); end
    seq.push_back(P_D); seq_last.push_back(0);
    case (op)
      LW: begin
        seq.push_back(P_MA); seq_last.push_back(0);
        for (int i = 0; i <= mw; i++) begin seq.push_back(P_MR); seq_last.push_back(0); end
        seq.push_back(P_MWB); seq_last.push_back(0);
      end
      SW: begin seq.push_back(P_MA); seq_last.push_back(0); seq.push_back(P_MW); seq_last.push_back(0); end
      RT: begin seq.push_back(P_EXR); seq_last.push_back(0); seq.push_back(P_AWB); seq_last.push_back(0); end
      IT: begin seq.push_back(P_EXI); seq_last.push_back(0); seq.push_back(P_AWB); seq_last.push_back(0); end
      BQ: begin seq.push_back(P_BEQ); seq_last.push_back(0); end
      JL: begin seq.push_back(P_JAL); seq_last.push_back(0); seq.push_back(P_AWB); seq_last.push_back(0); end
      default: ;
    endcase
  endfunction

  function automatic outs_t model_out(input phase_t p_in, input logic last, input logic [6:0] op,
                                      input logic [2:0] f3, input logic f7, input logic zero,
                                      input logic rst);
    outs_t  o;
    phase_t p;
    o     = '0;
    p     = rst ? P_F : p_in;
    o.imm = imm_expect(op);
    o.st  = st_code(p);
    case (p)
      P_F:   begin o.srcb = 2'b10; o.res = 2'b10; o.irw = last && !rst; o.pcw = last && !rst; end
      P_D:   begin o.srca = 2'b01; o.srcb = 2'b01; o.ill = !legal(op); end
      P_MA:  begin o.srca = 2'b10; o.srcb = 2'b01; end
      P_MR:  o.adr = 1'b1;
      P_MWB: begin o.res = 2'b01; o.regw = 1'b1; end
      P_MW:  begin o.adr = 1'b1; o.memw = 1'b1; end
      P_EXR: begin o.srca = 2'b10; o.aluc = alu_expect(op, f3, f7); end
      P_EXI: begin o.srca = 2'b10; o.srcb = 2'b01; o.aluc = alu_expect(op, f3, f7); end
      P_AWB: o.regw = 1'b1;
      P_JAL: begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
      default: begin o.srca = 2'b10; o.aluc = 3'b001; o.pcw = zero; end
    endcase
    return o;
  endfunction

  // ---------------- single compare process ----------------
  initial forever begin
    @(negedge clk);
    if (exp_valid) begin
      act_sel = (act_d == 0) ? act0 : act1;
      check(exp_tag, 32'(act_sel), 32'(exp_o));
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 of the next instruction's first cycle.
  task automatic do_reset(input int d, input int n);
    reset_v[d] = 1'b1;
    op_v[d]    = LW;
    for (int i = 0; i < n; i++) begin
      exp_o     = model_out(P_F, 1'b0, LW, f3_v[d], f7_v[d], zero_v[d], 1'b1);
      exp_tag   = $sformatf("reset d%0d c%0d", d, i);
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
    reset_v[d] = 1'b0;
  endtask

  task automatic run_instr(input int d, input int mw, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    build_seq(op, mw);
    op_v[d] = op;
    f3_v[d] = f3;
    f7_v[d] = f7;
    for (int i = 0; i < seq.size(); i++) begin
      zero_v[d] = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      exp_valid = 1'b1;
      if (i == abort_at) begin
        reset_v[d] = 1'b1;
        exp_o      = model_out(P_F, 1'b0, op, f3, f7, zero_v[d], 1'b1);
        exp_tag    = $sformatf("abort d%0d op%b step%0d", d, op, i);
        @(posedge clk); #1;
        reset_v[d] = 1'b0;
        return;
      end
      exp_o   = model_out(seq[i], seq_last[i], op, f3, f7, zero_v[d], 1'b0);
      exp_tag = $sformatf("d%0d op%b f3%b f7%b step%0d", d, op, f3, f7, i);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random(input int d, input int mw, input int n);
    logic [6:0] ops[7];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b1111111};
    for (int k = 0; k < n; k++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 7'b1111111) op = 7'($urandom_range(0, 127));
      run_instr(d, mw, op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    act_d = 0;
    do_reset(0, 2);

    fork begin #3; check("rel_irw", 32'(act0.irw), 32'd1); check("rel_pcw", 32'(act0.pcw), 32'd1); end join_none
    fork begin #43; check("lw_regw", 32'(act0.regw), 32'd1); check("lw_res", 32'(act0.res), 32'b01); end join_none
    run_instr(0, 0, LW, 3'b010, 1'b0, 2, -1);

    fork begin #23; check("sub_aluc", 32'(act0.aluc), 32'b001); end join_none
    run_instr(0, 0, RT, 3'b000, 1'b1, 2, -1);
    run_instr(0, 0, RT, 3'b000, 1'b0, 2, -1);
    fork begin #23; check("slt_aluc", 32'(act0.aluc), 32'b101); end join_none
    run_instr(0, 0, RT, 3'b010, 1'b0, 2, -1);
    fork begin #23; check("addi_aluc", 32'(act0.aluc), 32'b000); end join_none
    run_instr(0, 0, IT, 3'b000, 1'b1, 2, -1);

    fork begin #23; check("beq_taken", 32'(act0.pcw), 32'd1); check("beq_aluc", 32'(act0.aluc), 32'b001); end join_none
    run_instr(0, 0, BQ, 3'b000, 1'b0, 1, -1);
    fork begin #23; check("beq_not", 32'(act0.pcw), 32'd0); end join_none
    run_instr(0, 0, BQ, 3'b000, 1'b0, 0, -1);

    fork begin
      #13; check("jal_imm", 32'(act0.imm), 32'b11);
      #10; check("jal_pcw", 32'(act0.pcw), 32'd1);
      #10; check("jal_regw", 32'(act0.regw), 32'd1);
    end join_none
    run_instr(0, 0, JL, 3'b000, 1'b0, 2, -1);

    fork begin #13; check("ill_pulse", 32'(act0.ill), 32'd1); end join_none
    run_instr(0, 0, 7'b1111111, 3'b000, 1'b0, 2, -1);

    fork begin #33; check("sw_reset_memw", 32'(act0.memw), 32'd0); end join_none
    run_instr(0, 0, SW, 3'b010, 1'b0, 2, 3);
    run_instr(0, 0, SW, 3'b010, 1'b0, 2, -1);

    run_random(0, 0, 60);

    act_d = 1;
    do_reset(1, 2);
    fork begin
      #3;  check("mw2_irw0", 32'(act1.irw), 32'd0);
      #10; check("mw2_irw1", 32'(act1.irw), 32'd0);
      #10; check("mw2_irw2", 32'(act1.irw), 32'd1);
    end join_none
    run_instr(1, 2, LW, 3'b010, 1'b0, 2, -1);
    run_random(1, 2, 25);
    exp_valid = 1'b0;

    build_seq(LW, 0);         check("len_lw", 32'(seq.size()), 32'd5);
    build_seq(SW, 0);         check("len_sw", 32'(seq.size()), 32'd4);
    build_seq(RT, 0);         check("len_r", 32'(seq.size()), 32'd4);
    build_seq(JL, 0);         check("len_jal", 32'(seq.size()), 32'd4);
    build_seq(BQ, 0);         check("len_beq", 32'(seq.size()), 32'd3);
    build_seq(7'b1111111, 0); check("len_ill", 32'(seq.size()), 32'd2);
    build_seq(LW, 2);         check("len_lw_mw2", 32'(seq.size()), 32'd9);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
